sys_req_arbiter: RTL and testbench
==================================

# sys_req_arbiter

Round-robin arbiter that shares one co-simulation system-side access port (req/adr/rdWr/wrDat/rdDat/ack) among NUM_REQ TileLink slave bus functional models. It sits between the slave BFMs' system-side outputs and the single backdoor port serviced by the simulation host. It serialises accesses, routes read data and acknowledges back to the granted requester, and optionally times out hung accesses.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- ADR_WIDTH, 32: address width, identical to the slave BFMs.
- TIMEOUT_CYCLES, 1024: cycles to wait for sys_ack before forced completion; used only with SYS_ARB_TIMEOUT_EN; range 1..65535.
- clock  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_i  input  NUM_REQ  per-requester access request; held high until that requester's ack_o pulse.
- adr_i  input  NUM_REQ*ADR_WIDTH  packed addresses; requester k occupies slice k.
- rdWr_i  input  NUM_REQ  1 = read, 0 = write.
- wrDat_i  input  NUM_REQ*64  packed write data.
- ack_o  output  NUM_REQ  one-cycle completion pulse to the granted requester.
- rdDat_o  output  64  read data, valid in the ack_o cycle; broadcast to all requesters.
- err_o  output  1  high with ack_o when the access completed by timeout.
- sys_req  output  1  request to the system port.
- sys_adr  output  ADR_WIDTH  registered address of the granted requester.
- sys_rdWr  output  1  registered direction.
- sys_wrDat  output  64  registered write data.
- sys_rdDat  input  64  system read data, valid while sys_ack is high.
- sys_ack  input  1  system completion; sampled high for at least one cycle.
- grant_idx  output  $clog2(NUM_REQ)  index of the current or last grant, for debug.

## Operation
- FSM states: IDLE, ISSUE, RELEASE.
- IDLE: if any req_i bit is set, pick the first set bit at or after ptr, wrapping modulo NUM_REQ.
  - Register sys_adr, sys_rdWr and sys_wrDat from that requester.
  - Set sys_req=1 and grant_idx=winner.
  - Set ptr=(winner+1) mod NUM_REQ, then go to ISSUE.
- ISSUE: hold sys_* stable. When sys_ack=1:
  - Drop sys_req.
  - Pulse ack_o[grant_idx] for one cycle.
  - Set rdDat_o=sys_rdDat for a read, or leave rdDat_o unchanged for a write.
  - Go to RELEASE.
- RELEASE: wait until req_i[grant_idx]=0, then go to IDLE. This blocks re-grant of a request that is still held stale after its ack.
- Requests from other requesters stay pending throughout and are never dropped.
- A requester deasserting req_i while in ISSUE is a protocol violation. The arbiter ignores it and completes the access.
- Reset value of every output and internal register is 0: ack_o, rdDat_o, err_o, sys_req, sys_adr, sys_rdWr, sys_wrDat, grant_idx, ptr, timer. The FSM resets to IDLE.
- Reset asserted mid-access: sys_req drops immediately (asynchronous reset), no ack_o is issued, and the FSM returns to IDLE.

## Timing
- Grant latency: req_i sampled high in IDLE at edge N gives sys_req=1 after edge N.
- Completion: sys_ack sampled high at edge M gives ack_o pulse and sys_req=0 after edge M. ack_o is low again after edge M+1.
- Minimum turnaround per access is 3 cycles: IDLE → ISSUE → RELEASE → IDLE. The next grant is registered at the IDLE edge.
- sys_ack arriving in the same cycle sys_req rises (edge N+1) is accepted, giving a 1-cycle access.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SYS_ARB_TIMEOUT_EN defined:
  - A 16-bit timer clears on entry to ISSUE and increments each ISSUE cycle without sys_ack.
  - When the timer reaches TIMEOUT_CYCLES-1 without sys_ack, the access completes as normal (ack_o pulse, sys_req=0) with err_o=1 and rdDat_o=64'hDEAD_BEEF_DEAD_BEEF.
  - If sys_ack and timer expiry coincide, sys_ack wins and err_o=0.
  - A late sys_ack that arrives after the timeout, while not in ISSUE, is ignored.
- SYS_ARB_TIMEOUT_EN undefined:
  - No timer logic exists and err_o is tied to 0.
  - ISSUE waits indefinitely for sys_ack.

## Structure
- Package sys_arb_pkg contains:
  - the FSM state enum (IDLE, ISSUE, RELEASE);
  - the constant SYS_ARB_TIMEOUT_DATA = 64'hDEAD_BEEF_DEAD_BEEF;
  - the timer width constant (16).
- Sub-module sys_arb_rr_pick: combinational rotate, find-first-set, un-rotate. Inputs are req and ptr; outputs are any and winner index.
- The top level holds the FSM, the registers and the timer.

## Test plan
- Single read: req_i=4'b0010, adr_i[1]=32'h7000_0010, rdWr_i[1]=1; system acks 3 cycles later with sys_rdDat=64'h1234 → sys_adr=32'h7000_0010, ack_o=4'b0010 for one cycle, rdDat_o=64'h1234, err_o=0.
- Fairness: all four req_i held high, each dropped one cycle after its ack, then re-raised → grant order 0,1,2,3,0, with no requester granted twice in a row while others are pending.
- Stale request: requester 2 keeps req_i high for 5 cycles after its ack, requester 3 idle → no new sys_req until req_i[2] falls, then the FSM returns to IDLE.
- Zero-wait ack: sys_ack tied high, requester 0 writes wrDat=64'hA5A5 → sys_wrDat=64'hA5A5, ack_o[0] pulses one cycle after sys_req rises, rdDat_o unchanged.
- Reset mid-ISSUE: assert reset with sys_req=1 → sys_req=0 immediately, no ack_o. After release with req_i[3] still high → requester 3 is re-granted with ptr restarted at 0.
- With SYS_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, sys_ack never asserted → ack_o pulses 8 cycles after sys_req rises, with err_o=1 and rdDat_o=64'hDEAD_BEEF_DEAD_BEEF.

Source files
------------

// File: rtl/sys_arb_pkg.sv
// Shared types and constants for the system-port request arbiter.
package sys_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam logic [63:0] SYS_ARB_TIMEOUT_DATA = 64'hDEAD_BEEF_DEAD_BEEF;
    localparam int          SYS_ARB_TIMER_W      = 16;

endpackage

// File: rtl/sys_arb_rr_pick.sv
// Combinational round-robin picker: rotate requests by ptr, find first set, un-rotate.
module sys_arb_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       any,
    output logic [$clog2(NUM_REQ)-1:0] winner
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] rot;
    logic [IDX_W-1:0]   cand;
    logic               found;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        rot    = '0;
        cand   = '0;
        found  = 1'b0;
        winner = '0;
        any    = |req;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand   = IDX_W'((i + int'(ptr)) % NUM_REQ);
            rot[i] = req[cand];
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && rot[i]) begin
                found  = 1'b1;
                winner = IDX_W'((i + int'(ptr)) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/sys_req_arbiter.sv
// Round-robin arbiter sharing one system backdoor port among NUM_REQ slave BFMs.
// Optional hung-access timeout enabled by defining SYS_ARB_TIMEOUT_EN.
module sys_req_arbiter
    import sys_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADR_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_i,
    input  logic [NUM_REQ*ADR_WIDTH-1:0] adr_i,
    input  logic [NUM_REQ-1:0]           rdWr_i,
    input  logic [NUM_REQ*64-1:0]        wrDat_i,
    output logic [NUM_REQ-1:0]           ack_o,
    output logic [63:0]                  rdDat_o,
    output logic                         err_o,
    output logic                         sys_req,
    output logic [ADR_WIDTH-1:0]         sys_adr,
    output logic                         sys_rdWr,
    output logic [63:0]                  sys_wrDat,
    input  logic [63:0]                  sys_rdDat,
    input  logic                         sys_ack,
    output logic [$clog2(NUM_REQ)-1:0]   grant_idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("sys_req_arbiter: parameter out of range");
    end

    arb_state_e           state, state_d;
    logic [IDX_W-1:0]     ptr, ptr_d;
    logic [IDX_W-1:0]     grant_d;
    logic                 sys_req_d;
    logic [ADR_WIDTH-1:0] sys_adr_d;
    logic                 sys_rdwr_d;
    logic [63:0]          sys_wrdat_d;
    logic [NUM_REQ-1:0]   ack_d;
    logic [63:0]          rddat_d;
    logic                 pick_any;
    logic [IDX_W-1:0]     pick_winner;

`ifdef SYS_ARB_TIMEOUT_EN
    logic [SYS_ARB_TIMER_W-1:0] timer, timer_d;
    logic                       err_d;
`endif

    sys_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (req_i),
        .ptr    (ptr),
        .any    (pick_any),
        .winner (pick_winner)
    );

    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        grant_d     = grant_idx;
        sys_req_d   = sys_req;
        sys_adr_d   = sys_adr;
        sys_rdwr_d  = sys_rdWr;
        sys_wrdat_d = sys_wrDat;
        ack_d       = '0;
        rddat_d     = rdDat_o;
`ifdef SYS_ARB_TIMEOUT_EN
        timer_d     = timer;
        err_d       = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (pick_any) begin
                    sys_adr_d   = adr_i[int'(pick_winner)*ADR_WIDTH +: ADR_WIDTH];
                    sys_rdwr_d  = rdWr_i[pick_winner];
                    sys_wrdat_d = wrDat_i[int'(pick_winner)*64 +: 64];
                    sys_req_d   = 1'b1;
                    grant_d     = pick_winner;
                    ptr_d       = IDX_W'((int'(pick_winner) + 1) % NUM_REQ);
                    state_d     = ISSUE;
`ifdef SYS_ARB_TIMEOUT_EN
                    timer_d     = '0;
`endif
                end
            end
            ISSUE: begin
                // A requester dropping req_i here is ignored; only sys_ack (or timeout) ends the access.
                if (sys_ack) begin
                    sys_req_d        = 1'b0;
                    ack_d[grant_idx] = 1'b1;
                    if (sys_rdWr) begin
                        rddat_d = sys_rdDat;
                    end
                    state_d = RELEASE;
                end
`ifdef SYS_ARB_TIMEOUT_EN
                else if (timer == SYS_ARB_TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    sys_req_d        = 1'b0;
                    ack_d[grant_idx] = 1'b1;
                    err_d            = 1'b1;
                    rddat_d          = SYS_ARB_TIMEOUT_DATA;
                    state_d          = RELEASE;
                end else begin
                    timer_d = timer + 1'b1;
                end
`endif
            end
            RELEASE: begin
                // Hold off until the served requester drops its stale request.
                if (!req_i[grant_idx]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= '0;
            grant_idx <= '0;
            sys_req   <= 1'b0;
            sys_adr   <= '0;
            sys_rdWr  <= 1'b0;
            sys_wrDat <= '0;
            ack_o     <= '0;
            rdDat_o   <= '0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            grant_idx <= grant_d;
            sys_req   <= sys_req_d;
            sys_adr   <= sys_adr_d;
            sys_rdWr  <= sys_rdwr_d;
            sys_wrDat <= sys_wrdat_d;
            ack_o     <= ack_d;
            rdDat_o   <= rddat_d;
        end
    end

`ifdef SYS_ARB_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer <= '0;
            err_o <= 1'b0;
        end else begin
            timer <= timer_d;
            err_o <= err_d;
        end
    end
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sys_req_arbiter.sv
// Randomised self-checking bench for sys_req_arbiter against a round-robin reference model.
module tb_sys_req_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int IW = $clog2(N);

    logic              clock;
    logic              reset;
    logic [N-1:0]      req;
    logic [N*AW-1:0]   adr;
    logic [N-1:0]      rdwr;
    logic [N*64-1:0]   wrdat;
    logic [N-1:0]      ack_o;
    logic [63:0]       rdDat_o;
    logic              err_o;
    logic              sys_req;
    logic [AW-1:0]     sys_adr;
    logic              sys_rdWr;
    logic [63:0]       sys_wrDat;
    logic [63:0]       sys_rdDat;
    logic              sys_ack;
    logic [IW-1:0]     grant_idx;

    int checks = 0;
    int errors = 0;

    // Reference model: pending set, per-requester payload, rotating pointer, last read data.
    logic          pend [N];
    logic [AW-1:0] m_adr [N];
    logic          m_rd [N];
    logic [63:0]   m_wd [N];
    int            m_ptr;
    logic [63:0]   m_rddat;

    sys_req_arbiter #(.NUM_REQ(N), .ADR_WIDTH(AW), .TIMEOUT_CYCLES(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_i     (req),
        .adr_i     (adr),
        .rdWr_i    (rdwr),
        .wrDat_i   (wrdat),
        .ack_o     (ack_o),
        .rdDat_o   (rdDat_o),
        .err_o     (err_o),
        .sys_req   (sys_req),
        .sys_adr   (sys_adr),
        .sys_rdWr  (sys_rdWr),
        .sys_wrDat (sys_wrDat),
        .sys_rdDat (sys_rdDat),
        .sys_ack   (sys_ack),
        .grant_idx (grant_idx)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic int model_pick();
        for (int i = 0; i < N; i++) begin
            if (pend[(m_ptr + i) % N]) return (m_ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic raise(input int k, input logic [AW-1:0] a, input logic rd, input logic [63:0] wd);
        adr[k*AW +: AW]  = a;
        rdwr[k]          = rd;
        wrdat[k*64 +: 64] = wd;
        req[k]           = 1'b1;
        pend[k] = 1'b1; m_adr[k] = a; m_rd[k] = rd; m_wd[k] = wd;
    endtask

    task automatic apply_reset();
        reset = 1'b0; req = '0; sys_ack = 1'b0; sys_rdDat = '0;
        for (int k = 0; k < N; k++) pend[k] = 1'b0;
        m_ptr = 0; m_rddat = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    // Called at a negedge where the next rising edge is an IDLE edge with something pending.
    task automatic do_access(input int lat, input int hold, input logic [63:0] rd_val, output int got);
        int           w;
        logic [N-1:0] exp_ack;
        w = model_pick();
        got = -1;
        if (w < 0) begin
            errors++; checks++;
            $display("FAIL model_empty: no pending requester, required at least one");
            return;
        end
        @(negedge clock);
        got = int'(grant_idx);
        checks++;
        if (sys_req !== 1'b1 || grant_idx !== IW'(w)) begin
            errors++;
            $display("FAIL grant: sys_req=%0b grant_idx=%0d, required 1/%0d", sys_req, grant_idx, w);
        end
        checks++;
        if (sys_adr !== m_adr[w] || sys_rdWr !== m_rd[w] || sys_wrDat !== m_wd[w]) begin
            errors++;
            $display("FAIL payload: adr=%h rd=%0b wd=%h, required %h %0b %h",
                     sys_adr, sys_rdWr, sys_wrDat, m_adr[w], m_rd[w], m_wd[w]);
        end
        m_ptr = (w + 1) % N;
        for (int c = 0; c < lat; c++) begin
            @(negedge clock);
            checks++;
            if (sys_req !== 1'b1 || ack_o !== '0) begin
                errors++;
                $display("FAIL wait_ack: sys_req=%0b ack_o=%b, required 1/0000", sys_req, ack_o);
            end
        end
        sys_ack = 1'b1; sys_rdDat = rd_val;
        @(negedge clock);
        sys_ack = 1'b0;
        if (m_rd[w]) m_rddat = rd_val;
        exp_ack = '0; exp_ack[w] = 1'b1;
        checks++;
        if (ack_o !== exp_ack || sys_req !== 1'b0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL complete: ack_o=%b sys_req=%0b err_o=%0b, required %b/0/0", ack_o, sys_req, err_o, exp_ack);
        end
        checks++;
        if (rdDat_o !== m_rddat) begin
            errors++;
            $display("FAIL rddat: rdDat_o=%h, required %h", rdDat_o, m_rddat);
        end
        for (int c = 0; c < hold; c++) begin
            @(negedge clock);
            checks++;
            if (sys_req !== 1'b0 || ack_o !== '0) begin
                errors++;
                $display("FAIL stale_hold: sys_req=%0b ack_o=%b, required 0/0000", sys_req, ack_o);
            end
        end
        req[w] = 1'b0; pend[w] = 1'b0;
        @(negedge clock);
        checks++;
        if (ack_o !== '0 || sys_req !== 1'b0) begin
            errors++;
            $display("FAIL ack_pulse: ack_o=%b sys_req=%0b, required 0000/0", ack_o, sys_req);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (ack_o !== '0 || rdDat_o !== '0 || err_o !== 1'b0 || sys_req !== 1'b0 ||
            sys_adr !== '0 || sys_rdWr !== 1'b0 || sys_wrDat !== '0 || grant_idx !== '0) begin
            errors++;
            $display("FAIL reset_state: ack=%b rd=%h err=%0b req=%0b adr=%h dir=%0b wd=%h g=%0d, required all zero",
                     ack_o, rdDat_o, err_o, sys_req, sys_adr, sys_rdWr, sys_wrDat, grant_idx);
        end
    endtask

    task automatic test_single_read();
        int got;
        raise(1, 32'h7000_0010, 1'b1, {$urandom, $urandom});
        do_access(2, 0, 64'h1234, got);
        checks++;
        if (rdDat_o !== 64'h1234) begin
            errors++;
            $display("FAIL single_read_data: rdDat_o=%h, required 0000000000001234", rdDat_o);
        end
    endtask

    task automatic test_zero_wait();
        int got;
        raise(0, $urandom, 1'b0, 64'hA5A5);
        do_access(0, 0, {$urandom, $urandom}, got);
    endtask

    task automatic test_stale();
        int got;
        raise(2, $urandom, 1'($urandom), {$urandom, $urandom});
        do_access(1, 5, {$urandom, $urandom}, got);
        raise(3, $urandom, 1'($urandom), {$urandom, $urandom});
        do_access(0, 0, {$urandom, $urandom}, got);
    endtask

    task automatic test_reset_mid_issue();
        int got;
        raise(3, $urandom, 1'b1, {$urandom, $urandom});
        @(negedge clock);
        checks++;
        if (sys_req !== 1'b1) begin
            errors++;
            $display("FAIL mid_issue_grant: sys_req=%0b, required 1", sys_req);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (sys_req !== 1'b0 || ack_o !== '0 || grant_idx !== '0) begin
            errors++;
            $display("FAIL async_reset: sys_req=%0b ack_o=%b grant=%0d, required 0/0000/0", sys_req, ack_o, grant_idx);
        end
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        m_ptr = 0; m_rddat = '0;
        do_access(1, 0, {$urandom, $urandom}, got);
        checks++;
        if (got != 3) begin
            errors++;
            $display("FAIL regrant_after_reset: grant=%0d, required 3", got);
        end
    endtask

    task automatic test_fairness();
        int order [5] = '{0, 1, 2, 3, 0};
        int got;
        apply_reset();
        for (int k = 0; k < N; k++) raise(k, $urandom, 1'($urandom), {$urandom, $urandom});
        for (int i = 0; i < 5; i++) begin
            do_access($urandom_range(0, 2), 0, {$urandom, $urandom}, got);
            checks++;
            if (got != order[i]) begin
                errors++;
                $display("FAIL fairness_order[%0d]: grant=%0d, required %0d", i, got, order[i]);
            end
            if (got >= 0 && got < N) raise(got, $urandom, 1'($urandom), {$urandom, $urandom});
        end
        for (int k = 0; k < N; k++) begin
            while (pend[k]) do_access(0, 0, {$urandom, $urandom}, got);
        end
    endtask

    task automatic test_random();
        int          got;
        logic [N-1:0] mask;
        logic         none;
        for (int it = 0; it < 30; it++) begin
            mask = N'($urandom);
            for (int k = 0; k < N; k++) begin
                if (mask[k] && !pend[k]) raise(k, $urandom, 1'($urandom), {$urandom, $urandom});
            end
            none = 1'b1;
            for (int k = 0; k < N; k++) if (pend[k]) none = 1'b0;
            if (none) raise($urandom_range(0, N-1), $urandom, 1'($urandom), {$urandom, $urandom});
            do_access($urandom_range(0, 3), $urandom_range(0, 2), {$urandom, $urandom}, got);
        end
    endtask

`ifdef SYS_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int cnt;
        raise(1, $urandom, 1'b0, {$urandom, $urandom});
        @(negedge clock);
        checks++;
        if (sys_req !== 1'b1) begin
            errors++;
            $display("FAIL timeout_grant: sys_req=%0b, required 1", sys_req);
        end
        cnt = 0;
        while (ack_o === '0 && cnt < 20) begin
            @(negedge clock);
            cnt++;
        end
        checks++;
        if (cnt != 8 || ack_o !== 4'b0010 || err_o !== 1'b1 || sys_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_complete: cycles=%0d ack_o=%b err=%0b sys_req=%0b, required 8/0010/1/0",
                     cnt, ack_o, err_o, sys_req);
        end
        checks++;
        if (rdDat_o !== 64'hDEAD_BEEF_DEAD_BEEF) begin
            errors++;
            $display("FAIL timeout_data: rdDat_o=%h, required deadbeefdeadbeef", rdDat_o);
        end
        m_rddat = 64'hDEAD_BEEF_DEAD_BEEF;
        req[1] = 1'b0; pend[1] = 1'b0;
        @(negedge clock);
        checks++;
        if (err_o !== 1'b0 || ack_o !== '0) begin
            errors++;
            $display("FAIL timeout_pulse: err_o=%0b ack_o=%b, required 0/0000", err_o, ack_o);
        end
    endtask
`endif

    initial begin
        reset = 1'b0; req = '0; adr = '0; rdwr = '0; wrdat = '0;
        sys_ack = 1'b0; sys_rdDat = '0;
        test_reset();
        test_single_read();
        test_zero_wait();
        test_stale();
        test_reset_mid_issue();
        test_fairness();
        test_random();
`ifdef SYS_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
